fighter_pixel_arbiter: RTL
==========================

Name: fighter_pixel_arbiter

Overview:
- Shares one sprite index ROM and one 16-entry fighter palette lookup between two fighter sprites (P1, P2) on every VGA pixel.
- Per pixel: fetches each fighter's 4-bit colour index in turn, discards the transparent key, and composites by priority over the background.
- Emits registered 4/4/4 RGB to the VGA output stage.
- Sits between the VGA controller (DrawX/DrawY, pixel enable) and the colour mapper.

Parameters:
SPR_W, 64, sprite width in pixels
SPR_H, 96, sprite height in pixels
ADDR_W, 14, ROM address width
P1_BASE, 0, ROM word offset of P1 frame
P2_BASE, 6144, ROM word offset of P2 frame
TRANSP_IDX, 1, palette index treated as transparent (magenta key)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
pix_en  in  1  one-cycle strobe: DrawX/DrawY valid, start new pixel
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
p1_x, p1_y  in  10 each  P1 sprite top-left
p1_flip  in  1  P1 horizontal mirror
p2_x, p2_y  in  10 each  P2 sprite top-left
p2_flip  in  1  P2 horizontal mirror
p1_on_top  in  1  1: P1 drawn over P2; 0: P2 over P1
rom_rd  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM word address
rom_data  in  4  colour index, valid exactly 1 cycle after rom_rd
pal_index  out  4  palette lookup index (palette is combinational)
pal_rgb  in  12  {r,g,b} for pal_index, same cycle
bg_rgb  in  12  background colour for current pixel, held from pix_en until pix_valid
red, green, blue  out  4 each  composited colour
pix_valid  out  1  one-cycle strobe: red/green/blue updated
overrun  out  1  sticky: pix_en arrived while busy

Behaviour:
- Reset (async, active-high): state IDLE; rom_rd=0, rom_addr=0, pal_index=0, red/green/blue=0, pix_valid=0, overrun=0; captured indices and in-box flags cleared. Reset mid-pixel aborts the pixel; no pix_valid is emitted.
- FSM: IDLE -> FETCH1 -> FETCH2 -> RESOLVE -> IDLE. Only IDLE accepts pix_en.
- IDLE + pix_en:
  - Latch DrawX, DrawY, p2_* and p1_on_top.
  - Compute P1 hit and address combinationally; drive rom_rd=in1, rom_addr=addr1.
  - Go to FETCH1.
- Hit test, per fighter n:
  - lx = DrawX - pn_x and ly = DrawY - pn_y, computed 11-bit signed.
  - in_n = (0 <= lx < SPR_W) && (0 <= ly < SPR_H).
  - Sprite pixels off the screen edge are simply never hit.
- Address: lx' = pn_flip ? SPR_W-1-lx : lx; addr_n = Pn_BASE + ly*SPR_W + lx', truncated to ADDR_W. With power-of-two SPR_W the multiply is a shift.
- FETCH1: capture idx1 = in1 ? rom_data : TRANSP_IDX; drive rom_rd=in2, rom_addr=addr2; go to FETCH2.
- FETCH2: capture idx2 likewise; rom_rd=0; go to RESOLVE.
- RESOLVE:
  - top/bot = p1_on_top ? (idx1, idx2) : (idx2, idx1).
  - pal_index = (top != TRANSP_IDX) ? top : bot.
  - Colour = pal_rgb if the chosen index != TRANSP_IDX, else bg_rgb.
  - Register the colour into red/green/blue; pix_valid=1 on the following cycle.
  - Go to IDLE.
- Latency: pix_en at cycle t -> pix_valid high at t+4 with the new colour. red/green/blue hold between pixels. Minimum pix_en spacing is 4 cycles.
- pix_en in any non-IDLE state is ignored and sets overrun; overrun clears only on Reset.
- rom_rd stays 0 for a fighter not in box; no ROM access is wasted.
- Both fighters overlapping, both opaque: the top fighter wins. Both transparent or out of box: bg_rgb.
- pal_index returns to 0 outside RESOLVE.

Decomposition:
- Package fighter_gfx_pkg:
  - state enum (IDLE, FETCH1, FETCH2, RESOLVE);
  - TRANSP_IDX default;
  - rgb12_t typedef;
  - sprite dimension constants.
- Sub-module sprite_hit_addr: combinational hit test plus flip and address for one fighter, instantiated twice.

Test Plan:
- Reset asserted mid-FETCH2 -> outputs all 0, no pix_valid, state IDLE. Next pix_en produces a normal pixel 4 cycles later.
- P1 at (100,200), P2 far away, DrawX=110, DrawY=205, ROM returns 7, palette[7]=FFF -> rom_addr=5*64+10=330; one rom_rd only; pix_valid at t+4; rgb=F,F,F.
- Same pixel with p1_flip=1 -> rom_addr=5*64+53=373.
- P2 at (100,200) also, P2_BASE=6144, ROM returns P1=1 (transparent) and P2=9, p1_on_top=1 -> pal_index=9; output is palette[9] (C,1,0).
- Both fighters opaque at the same pixel, P1=3, P2=9 -> p1_on_top=1 gives (1,1,1); p1_on_top=0 gives (C,1,0).
- DrawX=99 (one pixel left of box), bg_rgb=0x48C -> rom_rd stays 0; rgb=4,8,C.
- pix_en pulsed 2 cycles after a previous pix_en -> second strobe ignored, overrun=1 and sticky; first pixel completes correctly.

Source files
------------

// File: rtl/fighter_gfx_pkg.sv
// Shared types and constants for the two-fighter sprite compositor.
// Holds the FSM encoding, colour type, default sprite geometry and key index.
package fighter_gfx_pkg;

    localparam int DEF_SPR_W   = 64;
    localparam int DEF_SPR_H   = 96;
    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_P1_BASE = 0;
    localparam int DEF_P2_BASE = 6144;

    localparam logic [3:0] DEF_TRANSP_IDX = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH1,
        FETCH2,
        RESOLVE
    } state_t;

    typedef logic [11:0] rgb12_t;

    // Priority pick: upper layer unless it is the colour key.
    function automatic logic [3:0] pick_idx(
        input logic [3:0] top,
        input logic [3:0] bot,
        input logic [3:0] key
    );
        return (top != key) ? top : bot;
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// Hit test, horizontal mirror and ROM address for one fighter sprite.
// Purely combinational; offsets are 11-bit signed so off-screen parts never hit.
module sprite_hit_addr
    import fighter_gfx_pkg::*;
#(
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BASE   = 0
) (
    input  logic [9:0]        draw_x_i,
    input  logic [9:0]        draw_y_i,
    input  logic [9:0]        pos_x_i,
    input  logic [9:0]        pos_y_i,
    input  logic              flip_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic signed [10:0] W_S = 11'(SPR_W);
    localparam logic signed [10:0] H_S = 11'(SPR_H);

    logic signed [10:0] lx;
    logic signed [10:0] ly;
    logic signed [10:0] lx_f;

    assign lx = $signed({1'b0, draw_x_i}) - $signed({1'b0, pos_x_i});
    assign ly = $signed({1'b0, draw_y_i}) - $signed({1'b0, pos_y_i});

    assign hit_o = (lx >= 11'sd0) && (lx < W_S)
                && (ly >= 11'sd0) && (ly < H_S);

    assign lx_f = flip_i ? (W_S - 11'sd1 - lx) : lx;

    assign addr_o = ADDR_W'(BASE)
                  + ADDR_W'($unsigned(ly)) * ADDR_W'(SPR_W)
                  + ADDR_W'($unsigned(lx_f));

endmodule

// File: rtl/fighter_pixel_arbiter.sv
// Per-pixel arbiter sharing one index ROM and palette between two fighters.
// Fetches P1 then P2, drops the colour key and composites over background.
module fighter_pixel_arbiter
    import fighter_gfx_pkg::*;
#(
    parameter int         SPR_W      = DEF_SPR_W,
    parameter int         SPR_H      = DEF_SPR_H,
    parameter int         ADDR_W     = DEF_ADDR_W,
    parameter int         P1_BASE    = DEF_P1_BASE,
    parameter int         P2_BASE    = DEF_P2_BASE,
    parameter logic [3:0] TRANSP_IDX = DEF_TRANSP_IDX
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        p1_x,
    input  logic [9:0]        p1_y,
    input  logic              p1_flip,
    input  logic [9:0]        p2_x,
    input  logic [9:0]        p2_y,
    input  logic              p2_flip,
    input  logic              p1_on_top,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pal_index,
    input  logic [11:0]       pal_rgb,
    input  logic [11:0]       bg_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              pix_valid,
    output logic              overrun
);

    state_t state_q, state_d;

    logic [9:0] drawx_q, drawy_q;
    logic [9:0] p2x_q, p2y_q;
    logic       p2flip_q, p1top_q;
    logic       in1_q, in2_q;
    logic [3:0] idx1_q, idx2_q;
    rgb12_t     rgb_q, rgb_d;
    logic       pix_valid_q;
    logic       overrun_q;

    logic              hit1, hit2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [3:0]        top_idx, bot_idx, sel_idx;
    logic              accept;

    assign accept = (state_q == IDLE) && pix_en;

    // P1 is tested on live inputs in the accept cycle only.
    sprite_hit_addr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .ADDR_W(ADDR_W),
        .BASE  (P1_BASE)
    ) u_p1 (
        .draw_x_i(DrawX),
        .draw_y_i(DrawY),
        .pos_x_i (p1_x),
        .pos_y_i (p1_y),
        .flip_i  (p1_flip),
        .hit_o   (hit1),
        .addr_o  (addr1)
    );

    // P2 is tested one cycle later from the latched copies.
    sprite_hit_addr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .ADDR_W(ADDR_W),
        .BASE  (P2_BASE)
    ) u_p2 (
        .draw_x_i(drawx_q),
        .draw_y_i(drawy_q),
        .pos_x_i (p2x_q),
        .pos_y_i (p2y_q),
        .flip_i  (p2flip_q),
        .hit_o   (hit2),
        .addr_o  (addr2)
    );

    assign top_idx = p1top_q ? idx1_q : idx2_q;
    assign bot_idx = p1top_q ? idx2_q : idx1_q;
    assign sel_idx = pick_idx(top_idx, bot_idx, TRANSP_IDX);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: fixed four-cycle walk, started only from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pix_en) state_d = FETCH1;
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = RESOLVE;
            RESOLVE: state_d = IDLE;
        endcase
    end

    // Outputs: ROM strobe only for in-box fighters, palette only in RESOLVE.
    always_comb begin
        rom_rd    = 1'b0;
        rom_addr  = '0;
        pal_index = 4'd0;
        rgb_d     = rgb_q;
        unique case (state_q)
            IDLE: begin
                if (pix_en && hit1) begin
                    rom_rd   = 1'b1;
                    rom_addr = addr1;
                end
            end
            FETCH1: begin
                if (hit2) begin
                    rom_rd   = 1'b1;
                    rom_addr = addr2;
                end
            end
            FETCH2: ;
            RESOLVE: begin
                pal_index = sel_idx;
                rgb_d     = (sel_idx != TRANSP_IDX) ? pal_rgb : bg_rgb;
            end
        endcase
    end

    // Pixel datapath: latch context, capture indices, register colour.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            drawx_q     <= '0;
            drawy_q     <= '0;
            p2x_q       <= '0;
            p2y_q       <= '0;
            p2flip_q    <= 1'b0;
            p1top_q     <= 1'b0;
            in1_q       <= 1'b0;
            in2_q       <= 1'b0;
            idx1_q      <= '0;
            idx2_q      <= '0;
            rgb_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= (state_q == RESOLVE);
            if (accept) begin
                drawx_q  <= DrawX;
                drawy_q  <= DrawY;
                p2x_q    <= p2_x;
                p2y_q    <= p2_y;
                p2flip_q <= p2_flip;
                p1top_q  <= p1_on_top;
                in1_q    <= hit1;
            end
            if (state_q == FETCH1) begin
                idx1_q <= in1_q ? rom_data : TRANSP_IDX;
                in2_q  <= hit2;
            end
            if (state_q == FETCH2)
                idx2_q <= in2_q ? rom_data : TRANSP_IDX;
            rgb_q <= rgb_d;
        end
    end

    // Sticky flag for strobes that arrive while a pixel is in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                          overrun_q <= 1'b0;
        else if (pix_en && state_q != IDLE) overrun_q <= 1'b1;
    end

    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign pix_valid = pix_valid_q;
    assign overrun   = overrun_q;

endmodule
